// File: rtl/eq1_always_amisha_pkg.sv
// Shared defaults for the eq1_always_amisha compare stage.
package eq1_always_amisha_pkg;

    // Default operand width gives the classic 1-bit comparator.
    localparam int DEF_WIDTH = 1;

    // Default width of the saturating mismatch counter.
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/eq1_always_amisha_cell.sv
// One-bit equality cell: p is high when a and b carry the same value.
module eq1_cell_amisha (
    input  logic a,
    input  logic b,
    output logic p
);

    // Sum-of-products form: both low or both high.
    always_comb begin
        p = (~a & ~b) | (a & b);
    end

endmodule

// File: rtl/eq1_always_amisha.sv
// Leaf equality compare stage with a registered result and a saturating
// count of enabled cycles on which the operands differed.
module eq1_always_amisha
    import eq1_always_amisha_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_amisha,
    input  logic             rst_amisha,
    input  logic             en_amisha,
    input  logic [WIDTH-1:0] i0_amisha,
    input  logic [WIDTH-1:0] i1_amisha,
    output logic             eq_amisha,
    output logic             eq_q_amisha,
    output logic [CNT_W-1:0] mis_cnt_amisha
);

    logic [WIDTH-1:0] p_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        eq1_cell_amisha u_cell (
            .a (i0_amisha[i]),
            .b (i1_amisha[i]),
            .p (p_vec[i])
        );
    end

    // Operands are equal only when every bit cell reports a match.
    always_comb begin
        eq_amisha = &p_vec;
    end

    // Registered result and mismatch counter; the counter sticks at all-ones
    // until reset so a downstream consumer never sees it wrap back to zero.
    always_ff @(posedge clk_amisha) begin
        if (rst_amisha) begin
            eq_q_amisha    <= 1'b0;
            mis_cnt_amisha <= '0;
        end else if (en_amisha) begin
            eq_q_amisha <= eq_amisha;
            if (!eq_amisha && (mis_cnt_amisha != '1)) begin
                mis_cnt_amisha <= mis_cnt_amisha + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eq1_always_amisha.sv
// Bench for eq1_always_amisha: three instances (1-bit/8-bit counter,
// 1-bit/2-bit counter, 4-bit/8-bit counter) driven in lockstep.
module tb_eq1_always_amisha;

    logic       clk_amisha = 1'b0;
    bit         clk_run    = 1'b0;
    logic       rst_amisha = 1'b0;
    logic       en_amisha  = 1'b0;
    logic       i0_1 = 1'b0, i1_1 = 1'b0;
    logic [3:0] i0_4 = 4'h0, i1_4 = 4'h0;

    logic       eq_a, eq_q_a, eq_b, eq_q_b, eq_c, eq_q_c;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    // model state
    logic       ma_q, mb_q, mc_q;
    logic [7:0] ma_c, mc_c;
    logic [1:0] mb_c;

    eq1_always_amisha #(.WIDTH(1), .CNT_W(8)) dut_a (
        .clk_amisha(clk_amisha), .rst_amisha(rst_amisha), .en_amisha(en_amisha),
        .i0_amisha(i0_1), .i1_amisha(i1_1),
        .eq_amisha(eq_a), .eq_q_amisha(eq_q_a), .mis_cnt_amisha(cnt_a)
    );

    eq1_always_amisha #(.WIDTH(1), .CNT_W(2)) dut_b (
        .clk_amisha(clk_amisha), .rst_amisha(rst_amisha), .en_amisha(en_amisha),
        .i0_amisha(i0_1), .i1_amisha(i1_1),
        .eq_amisha(eq_b), .eq_q_amisha(eq_q_b), .mis_cnt_amisha(cnt_b)
    );

    eq1_always_amisha #(.WIDTH(4), .CNT_W(8)) dut_c (
        .clk_amisha(clk_amisha), .rst_amisha(rst_amisha), .en_amisha(en_amisha),
        .i0_amisha(i0_4), .i1_amisha(i1_4),
        .eq_amisha(eq_c), .eq_q_amisha(eq_q_c), .mis_cnt_amisha(cnt_c)
    );

    // Clock only toggles once the clocked phase begins.
    always begin
        #5;
        if (clk_run) clk_amisha = ~clk_amisha;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, check combinational outputs at once,
    // predict the registered outputs, then compare them after the edge.
    task automatic drive(input logic rst_v, input logic en_v, input logic a0, input logic a1,
                         input logic [3:0] c0, input logic [3:0] c1);
        logic [31:0] obs [6];
        exp_t        e;
        rst_amisha = rst_v;
        en_amisha  = en_v;
        i0_1 = a0;
        i1_1 = a1;
        i0_4 = c0;
        i1_4 = c1;
        #1;
        check_val("eq_a", {31'b0, eq_a}, {31'b0, (a0 == a1)});
        check_val("eq_b", {31'b0, eq_b}, {31'b0, (a0 == a1)});
        check_val("eq_c", {31'b0, eq_c}, {31'b0, (c0 == c1)});

        if (rst_v) begin
            ma_q = 1'b0; ma_c = 8'd0;
            mb_q = 1'b0; mb_c = 2'd0;
            mc_q = 1'b0; mc_c = 8'd0;
        end else if (en_v) begin
            ma_q = (a0 == a1);
            mb_q = (a0 == a1);
            mc_q = (c0 == c1);
            if ((a0 != a1) && (ma_c != 8'hFF)) ma_c = ma_c + 8'd1;
            if ((a0 != a1) && (mb_c != 2'h3))  mb_c = mb_c + 2'd1;
            if ((c0 != c1) && (mc_c != 8'hFF)) mc_c = mc_c + 8'd1;
        end
        push_exp("eq_q_a", {31'b0, ma_q});
        push_exp("cnt_a",  {24'b0, ma_c});
        push_exp("eq_q_b", {31'b0, mb_q});
        push_exp("cnt_b",  {30'b0, mb_c});
        push_exp("eq_q_c", {31'b0, mc_q});
        push_exp("cnt_c",  {24'b0, mc_c});

        @(posedge clk_amisha);
        #1;
        obs[0] = {31'b0, eq_q_a};
        obs[1] = {24'b0, cnt_a};
        obs[2] = {31'b0, eq_q_b};
        obs[3] = {30'b0, cnt_b};
        obs[4] = {31'b0, eq_q_c};
        obs[5] = {24'b0, cnt_c};
        for (int k = 0; k < 6; k++) begin
            if (sb_q.size() == 0) begin
                check_val("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val(e.tag, obs[k], e.exp);
            end
        end
    endtask

    initial begin
        logic [1:0] pat;
        logic [7:0] v;

        // Combinational path with no clock running.
        for (int p = 0; p < 4; p++) begin
            pat  = p[1:0];
            i0_1 = pat[1];
            i1_1 = pat[0];
            #100;
            check_val("eq_noclk_a", {31'b0, eq_a}, {31'b0, (pat[1] == pat[0])});
            check_val("eq_noclk_b", {31'b0, eq_b}, {31'b0, (pat[1] == pat[0])});
        end

        clk_run = 1'b1;

        // Reset for two cycles, second one with enable also high.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 4'h2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3);

        // Mismatch then match with enable.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hA, 4'hA);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 4'hB);

        // Enable low: registers hold.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h6);

        // Five enabled mismatches: 2-bit counter saturates at 3.
        for (int n = 0; n < 5; n++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1);
        end

        // Reset clears the saturated counter.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 4'h8);

        // Exhaustive 4-bit operand sweep.
        for (int x = 0; x < 256; x++) begin
            v = x[7:0];
            drive(1'b0, 1'b1, v[0], v[4], v[3:0], v[7:4]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
